counter_sched: RTL and testbench

- Round-robin scheduler that shares one 4-bit counter (inc/load/reset/in, 4-bit value out) between NREQ requesters.
- Each requester issues INC, LOAD, CLEAR or READ operations over a valid/ready handshake.
- The block serialises them into single-cycle strobes on the counter's control pins and returns the post-operation count to the winner.

---
 rtl/counter_sched_pkg.sv | 20 ++
 rtl/counter_sched_arbiter.sv | 32 +++
 rtl/counter_sched.sv | 122 ++++++++++++
 tb/tb_counter_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter_sched round-robin counter scheduler.
package counter_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_INC   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_sched_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping at NREQ-1.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    enable,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDXW = $clog2(NREQ);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDXW'(cand);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Serialises READ/INC/LOAD/CLEAR requests from NREQ requesters onto one shared counter.
// Define COUNTER_SCHED_SAT_EN to make INC saturate at the maximum count instead of wrapping.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_wrap,
  output logic                    busy,
  output logic                    cnt_inc,
  output logic                    cnt_load,
  output logic                    cnt_clear,
  output logic [WIDTH-1:0]        cnt_in,
  input  logic [WIDTH-1:0]        cnt_value
);

  localparam int IDXW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, idx_q, win_idx;
  op_t               op_q, win_op;
  logic [WIDTH-1:0]  pre_q, win_data;
  logic [NREQ-1:0]   grant;
  logic              arb_en, take, inc_go;

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_en = (state_q == ST_IDLE) && !reset;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (arb_en),
    .grant  (grant),
    .idx    (win_idx)
  );

  assign req_ready = grant;
  assign take      = |grant;
  assign win_op    = op_t'(req_op[2*win_idx +: 2]);
  assign win_data  = req_data[WIDTH*win_idx +: WIDTH];

`ifdef COUNTER_SCHED_SAT_EN
  assign inc_go = (win_op == OP_INC) && (cnt_value != CNT_MAX);
`else
  assign inc_go = (win_op == OP_INC);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes are decided at the handshake so they are clean registered pulses during ISSUE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      idx_q     <= '0;
      op_q      <= OP_READ;
      pre_q     <= '0;
      cnt_inc   <= 1'b0;
      cnt_load  <= 1'b0;
      cnt_clear <= 1'b0;
      cnt_in    <= '0;
    end else begin
      cnt_inc   <= 1'b0;
      cnt_load  <= 1'b0;
      cnt_clear <= 1'b0;
      cnt_in    <= '0;
      if (take) begin
        idx_q     <= win_idx;
        op_q      <= win_op;
        pre_q     <= cnt_value;
        cnt_inc   <= inc_go;
        cnt_load  <= (win_op == OP_LOAD);
        cnt_clear <= (win_op == OP_CLEAR);
        cnt_in    <= win_data;
      end
      if (state_q == ST_CAPTURE) begin
        ptr_q <= (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_wrap  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (take) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy    = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy             = 1'b1;
        rsp_valid[idx_q] = 1'b1;
        rsp_data         = cnt_value;
        rsp_wrap         = (op_q == OP_INC) && (pre_q == CNT_MAX);
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched: directed scenarios then randomized traffic against a reference model.
module tb_counter_sched;
  import counter_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_wrap;
  logic                  busy;
  logic                  cnt_inc;
  logic                  cnt_load;
  logic                  cnt_clear;
  logic [WIDTH-1:0]      cnt_in;
  logic [WIDTH-1:0]      cnt_value;

  counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_wrap  (rsp_wrap),
    .busy      (busy),
    .cnt_inc   (cnt_inc),
    .cnt_load  (cnt_load),
    .cnt_clear (cnt_clear),
    .cnt_in    (cnt_in),
    .cnt_value (cnt_value)
  );

  always #5 clock = ~clock;

  // The shared 4-bit counter that the scheduler drives; block reset leaves it alone.
  logic [WIDTH-1:0] cnt_reg = '0;
  always @(posedge clock) begin
    if (cnt_clear)     cnt_reg <= '0;
    else if (cnt_load) cnt_reg <= cnt_in;
    else if (cnt_inc)  cnt_reg <= cnt_reg + 1'b1;
  end
  assign cnt_value = cnt_reg;

  typedef struct {
    int idx;
    int data;
    bit wrap;
    int hs_cyc;
    int pre;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int   cyc = 0;
  int   model_ptr = 0;
  int   model_cnt = 0;
  int   idle_at = 0;
  bit   reset_in_issue = 1'b0;
  logic [WIDTH+2:0] exp_strobe = '0;

  int   mon_win, mon_j, mon_op, mon_d, mon_post;
  bit   mon_inc, mon_wrap;
  exp_t mon_e;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: predicts grants and strobes from the request vector, scores every response.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      if (reset_in_issue && sb_q.size() > 0) model_cnt = sb_q[0].pre;
      reset_in_issue = 1'b0;
      sb_q.delete();
      model_ptr  = 0;
      idle_at    = cyc;
      exp_strobe = '0;
    end else begin
      checkOutput("strobes", {cnt_inc, cnt_load, cnt_clear, cnt_in}, exp_strobe);
      exp_strobe = '0;
      checkOutput("busy", busy, (cyc < idle_at));

      mon_win = -1;
      if (cyc >= idle_at) begin
        for (int k = 0; k < NREQ; k++) begin
          mon_j = (model_ptr + k) % NREQ;
          if (mon_win < 0 && req_valid[mon_j]) mon_win = mon_j;
        end
      end
      checkOutput("req_ready", req_ready, (mon_win >= 0) ? (64'd1 << mon_win) : 64'd0);

      if (mon_win >= 0) begin
        mon_op   = int'(req_op[2*mon_win +: 2]);
        mon_d    = int'(req_data[WIDTH*mon_win +: WIDTH]);
        mon_inc  = 1'b0;
        mon_wrap = 1'b0;
        case (mon_op)
          0: mon_post = model_cnt;
          1: begin
            if (model_cnt == MAXV) begin
              mon_wrap = 1'b1;
`ifdef COUNTER_SCHED_SAT_EN
              mon_post = MAXV;
`else
              mon_post = 0;
              mon_inc  = 1'b1;
`endif
            end else begin
              mon_post = model_cnt + 1;
              mon_inc  = 1'b1;
            end
          end
          2: mon_post = mon_d;
          default: mon_post = 0;
        endcase
        sb_q.push_back('{idx: mon_win, data: mon_post, wrap: mon_wrap, hs_cyc: cyc, pre: model_cnt});
        exp_strobe = {mon_inc, (mon_op == 2), (mon_op == 3), WIDTH'(mon_d)};
        model_cnt  = mon_post;
        model_ptr  = (mon_win + 1) % NREQ;
        idle_at    = cyc + 3;
      end

      if (rsp_valid != '0) begin
        if (sb_q.size() == 0) begin
          checkOutput("rsp_unexpected", rsp_valid, 0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("rsp_valid", rsp_valid, 64'd1 << mon_e.idx);
          checkOutput("rsp_data", rsp_data, mon_e.data);
          checkOutput("rsp_wrap", rsp_wrap, mon_e.wrap);
          checkOutput("rsp_latency", cyc - mon_e.hs_cyc, 2);
        end
      end else begin
        checkOutput("rsp_idle_zero", {rsp_data, rsp_wrap}, 0);
        if (sb_q.size() > 0 && cyc > sb_q[0].hs_cyc + 2) begin
          mon_e = sb_q.pop_front();
          checkOutput("rsp_missing", rsp_valid, 64'd1 << mon_e.idx);
        end
      end
    end
  end

  // One clock of requester behaviour: drop served requests, optionally issue or abandon others.
  task automatic applyCycle(input bit rnd);
    logic [NREQ-1:0] served;
    @(negedge clock);
    served = req_valid & req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (served[i]) req_valid[i] = 1'b0;
      if (rnd) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_op[2*i +: 2]         = 2'($urandom_range(0, 3));
          req_data[WIDTH*i +: WIDTH] = WIDTH'($urandom_range(0, MAXV));
          req_valid[i]             = 1'b1;
        end else if (req_valid[i] && !served[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] mask, input logic [2*NREQ-1:0] ops,
                               input logic [WIDTH*NREQ-1:0] data);
    req_op    = ops;
    req_data  = data;
    req_valid = mask;
    for (int n = 0; n < 40 && req_valid != '0; n++) applyCycle(1'b0);
    checkOutput("requests_served", req_valid, 0);
    repeat (3) applyCycle(1'b0);
  endtask

  initial begin
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_outputs",
                {req_ready, rsp_valid, rsp_data, rsp_wrap, busy, cnt_inc, cnt_load, cnt_clear, cnt_in}, 0);
    reset = 1'b0;

    $display("[TB] single INC from 3");
    applyStimulus(4'b0001, 8'b00_00_00_10, 16'h0003);
    applyStimulus(4'b0001, 8'b00_00_00_01, 16'h0000);

    $display("[TB] reset during ISSUE");
    req_op    = 8'b00_00_00_01;
    req_valid = 4'b0001;
    for (int n = 0; n < 10 && !req_ready[0]; n++) @(negedge clock);
    checkOutput("pre_reset_grant", req_ready, 4'b0001);
    @(posedge clock);
    #1;
    req_valid = '0;
    #6;
    reset_in_issue = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("reset_async",
                {req_ready, rsp_valid, rsp_data, rsp_wrap, busy, cnt_inc, cnt_load, cnt_clear, cnt_in}, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(4'b0101, 8'b00_00_00_00, 16'h0000);

    $display("[TB] LOAD then READ on requester 1");
    applyStimulus(4'b0010, 8'b00_00_10_00, 16'h00A0);
    applyStimulus(4'b0010, 8'b00_00_00_00, 16'h0000);

    $display("[TB] fairness with all requesters holding INC");
    applyStimulus(4'b1000, 8'b11_00_00_00, 16'h0000);
    applyStimulus(4'b1111, 8'b01_01_01_01, 16'h0000);

    $display("[TB] INC at maximum count");
    applyStimulus(4'b0001, 8'b00_00_00_10, 16'h000F);
    applyStimulus(4'b0010, 8'b00_00_01_00, 16'h0000);

    $display("[TB] CLEAR competing with LOAD");
    applyStimulus(4'b1100, 8'b10_11_00_00, 16'h5000);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) applyCycle(1'b1);
    req_valid = '0;
    for (int n = 0; n < 10 && sb_q.size() > 0; n++) applyCycle(1'b0);
    checkOutput("final_drain", sb_q.size(), 0);
    checkOutput("final_count", cnt_reg, model_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
